// File: rtl/dm_pkg.sv
// Shared definitions for the disparity-map datapath: frame geometry, BRAM widths and
// the row-loader state encoding.
package dm_pkg;

  localparam int unsigned HRES                = 640;
  localparam int unsigned VRES                = 480;
  localparam int unsigned NUM_OF_ROWS_IN_BRAM = 8;
  localparam int unsigned BRAM_DATA_WIDTH     = 16;
  localparam int unsigned BRAM_ADDR_WIDTH     = 13;
  localparam int unsigned BRAM_WE_WIDTH       = 1;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StRefill
  } state_e;

endpackage

// File: rtl/bram_row_loader_if.sv
// Pixel-pair stream in, BRAM port-A write bus out. The loader uses the master modport,
// the stream source / BRAM side uses the slave modport.
interface bram_row_loader_if #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned WeWidth   = 1
);

  logic                 s_valid;
  logic                 s_ready;
  logic [DataWidth-1:0] s_data_search;
  logic [DataWidth-1:0] s_data_ref;

  logic                 ena;
  logic [WeWidth-1:0]   wea;
  logic [AddrWidth-1:0] addra;
  logic [DataWidth-1:0] dina_search;
  logic [DataWidth-1:0] dina_ref;

  modport master (
    input  s_valid, s_data_search, s_data_ref,
    output s_ready, ena, wea, addra, dina_search, dina_ref
  );

  modport slave (
    output s_valid, s_data_search, s_data_ref,
    input  s_ready, ena, wea, addra, dina_search, dina_ref
  );

endinterface

// File: rtl/row_addr_gen.sv
// Column counter plus running slot base for the circular row buffer; the base steps by
// HRES per completed row and wraps after the last slot, so no multiplier is needed.
module row_addr_gen #(
  parameter int unsigned HRES       = 640,
  parameter int unsigned NUM_ROWS   = 8,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  row_done_o,
  output logic                  mid_row_o
);

  localparam int unsigned ColW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [ColW-1:0]       LastCol  = ColW'(HRES - 1);
  localparam logic [ADDR_WIDTH-1:0] RowStep  = ADDR_WIDTH'(HRES);
  localparam logic [ADDR_WIDTH-1:0] LastBase = ADDR_WIDTH'(HRES * (NUM_ROWS - 1));

  logic [ColW-1:0]       col_q, col_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  last_col;

  assign last_col   = (col_q == LastCol);
  assign row_done_o = adv_i && last_col;
  assign mid_row_o  = (col_q != '0);
  assign addr_o     = base_q + ADDR_WIDTH'(col_q);

  always_comb begin
    col_d  = col_q;
    base_d = base_q;
    if (clr_i) begin
      col_d  = '0;
      base_d = '0;
    end else if (adv_i) begin
      if (last_col) begin
        col_d  = '0;
        base_d = (base_q == LastBase) ? '0 : base_q + RowStep;
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/bram_row_loader.sv
// Port-A sequencer for the search/ref BRAM pair: primes the row window, then refills the
// oldest slot after each finished_row until the whole frame has been loaded.
module bram_row_loader #(
  parameter int unsigned HRES                = dm_pkg::HRES,
  parameter int unsigned VRES                = dm_pkg::VRES,
  parameter int unsigned NUM_OF_ROWS_IN_BRAM = dm_pkg::NUM_OF_ROWS_IN_BRAM,
  parameter int unsigned BRAM_DATA_WIDTH     = dm_pkg::BRAM_DATA_WIDTH,
  parameter int unsigned BRAM_ADDR_WIDTH     = dm_pkg::BRAM_ADDR_WIDTH,
  parameter int unsigned BRAM_WE_WIDTH       = dm_pkg::BRAM_WE_WIDTH
) (
  input  logic                                   clka,
  input  logic                                   reset,
  input  logic                                   frame_start,
  input  logic                                   finished_row,
  bram_row_loader_if.master                      bus_io,
  output logic                                   go,
  output logic                                   busy_search,
  output logic                                   busy_ref,
  output logic [$clog2(NUM_OF_ROWS_IN_BRAM)-1:0] oldest_slot,
  output logic                                   frame_done
);

  import dm_pkg::*;

  localparam int unsigned SlotW = $clog2(NUM_OF_ROWS_IN_BRAM);
  localparam int unsigned RowW  = $clog2(VRES + 1);

  state_e                     state_q, state_d;
  logic [RowW-1:0]            rows_q, rows_d;
  logic [SlotW-1:0]           oldest_q, oldest_d;
  logic                       go_q, go_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;
  logic                       ena_q;
  logic [BRAM_WE_WIDTH-1:0]   wea_q;
  logic [BRAM_ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [BRAM_DATA_WIDTH-1:0] dina_search_q, dina_search_d;
  logic [BRAM_DATA_WIDTH-1:0] dina_ref_q, dina_ref_d;

  logic                       s_ready;
  logic                       xfer;
  logic                       start_frame;
  logic                       row_done;
  logic                       mid_row;
  logic [BRAM_ADDR_WIDTH-1:0] row_addr;

  assign s_ready     = (state_q == StPrime) || (state_q == StRefill);
  assign xfer        = bus_io.s_valid && s_ready;
  assign start_frame = (state_q == StIdle) && frame_start;

  row_addr_gen #(
    .HRES       (HRES),
    .NUM_ROWS   (NUM_OF_ROWS_IN_BRAM),
    .ADDR_WIDTH (BRAM_ADDR_WIDTH)
  ) u_row_addr_gen (
    .clk_i      (clka),
    .rst_i      (reset),
    .clr_i      (start_frame),
    .adv_i      (xfer),
    .addr_o     (row_addr),
    .row_done_o (row_done),
    .mid_row_o  (mid_row)
  );

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    oldest_d     = oldest_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d  = StPrime;
          rows_d   = '0;
          oldest_d = '0;
        end
      end
      StPrime: begin
        if (row_done) begin
          rows_d = rows_q + RowW'(1);
          if (rows_q == RowW'(NUM_OF_ROWS_IN_BRAM - 1)) state_d = StRun;
        end
      end
      StRun: begin
        if (finished_row) begin
          if (rows_q < RowW'(VRES)) begin
            state_d = StRefill;
          end else begin
            state_d      = StIdle;
            frame_done_d = 1'b1;
          end
        end
      end
      StRefill: begin
        if (row_done) begin
          rows_d   = rows_q + RowW'(1);
          oldest_d = (oldest_q == SlotW'(NUM_OF_ROWS_IN_BRAM - 1)) ? '0 : oldest_q + SlotW'(1);
          state_d  = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // go trails entry to StRun by a cycle, so it rises after the final write has landed.
  always_comb begin
    go_d          = (state_q == StRun) && !finished_row;
    busy_d        = xfer || (s_ready && mid_row);
    addra_d       = addra_q;
    dina_search_d = dina_search_q;
    dina_ref_d    = dina_ref_q;
    if (xfer) begin
      addra_d       = row_addr;
      dina_search_d = bus_io.s_data_search;
      dina_ref_d    = bus_io.s_data_ref;
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q       <= StIdle;
      rows_q        <= '0;
      oldest_q      <= '0;
      go_q          <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      ena_q         <= 1'b0;
      wea_q         <= '0;
      addra_q       <= '0;
      dina_search_q <= '0;
      dina_ref_q    <= '0;
    end else begin
      state_q       <= state_d;
      rows_q        <= rows_d;
      oldest_q      <= oldest_d;
      go_q          <= go_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      ena_q         <= xfer;
      wea_q         <= {BRAM_WE_WIDTH{xfer}};
      addra_q       <= addra_d;
      dina_search_q <= dina_search_d;
      dina_ref_q    <= dina_ref_d;
    end
  end

  assign bus_io.s_ready     = s_ready;
  assign bus_io.ena         = ena_q;
  assign bus_io.wea         = wea_q;
  assign bus_io.addra       = addra_q;
  assign bus_io.dina_search = dina_search_q;
  assign bus_io.dina_ref    = dina_ref_q;
  assign go                 = go_q;
  assign busy_search        = busy_q;
  assign busy_ref           = busy_q;
  assign oldest_slot        = oldest_q;
  assign frame_done         = frame_done_q;

endmodule
